// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority search for grant_arbiter_4.
// The optional forced-release feature is selected by ARB_TIMEOUT_EN.
package arb_pkg;

    localparam int ARB_N   = 4;
    localparam int ARB_IDW = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               found;
        logic [ARB_IDW-1:0] id;
    } arb_pick_t;

    // Walk offsets from high to low so the lowest offset from ptr wins.
    function automatic arb_pick_t rr_pick(input logic [ARB_N-1:0]   req,
                                          input logic [ARB_IDW-1:0] ptr);
        arb_pick_t          pick;
        logic [ARB_IDW-1:0] idx;
        pick.found = 1'b0;
        pick.id    = 2'b00;
        for (int k = ARB_N - 1; k >= 0; k--) begin
            idx = ptr + k[ARB_IDW-1:0];
            if (req[idx]) begin
                pick.found = 1'b1;
                pick.id    = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grant_dec_2to4.sv
// Enabled 2-to-4 one-hot decoder used to turn the owner index into grant lines.
module grant_dec_2to4
    import arb_pkg::*;
(
    input  logic [ARB_IDW-1:0] id,
    input  logic               en,
    output logic [ARB_N-1:0]   y
);

    // One-hot decode gated by the enable.
    always_comb begin
        y = 4'b0000;
        if (en) begin
            case (id)
                2'd0:    y = 4'b0001;
                2'd1:    y = 4'b0010;
                2'd2:    y = 4'b0100;
                2'd3:    y = 4'b1000;
                default: y = 4'b0000;
            endcase
        end else begin
            y = 4'b0000;
        end
    end

endmodule

// File: rtl/grant_arbiter_4.sv
// Four-way round-robin arbiter with registered owner index and decoded one-hot grant.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD forced release and the timeout port.
module grant_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ARB_N-1:0]   req,
    input  logic               done,
    output logic [ARB_N-1:0]   grant,
    output logic [ARB_IDW-1:0] grant_id,
    output logic               grant_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    if (MAX_HOLD < 2) begin : g_max_hold_check
        $error("grant_arbiter_4: MAX_HOLD must be at least 2");
    end

    arb_state_e         state_r;
    arb_state_e         state_nx_s;
    logic [ARB_IDW-1:0] ptr_r;
    logic [ARB_IDW-1:0] grant_id_r;
    arb_pick_t          pick_s;
    logic               release_s;
    logic               expire_s;
    logic               dec_en_s;

    assign pick_s    = rr_pick(req, ptr_r);
    assign release_s = done | ~req[grant_id_r];

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              timeout_r;

    assign expire_s = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
    assign timeout  = timeout_r;

    // Hold counter and timeout pulse; a normal release suppresses the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else if (state_r == BUSY) begin
            hold_cnt_r <= hold_cnt_r + 1'b1;
            timeout_r  <= expire_s & ~release_s;
        end else begin
            hold_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = pick_s.found ? BUSY : IDLE;
            BUSY:    state_nx_s = (release_s | expire_s) ? IDLE : BUSY;
            default: state_nx_s = IDLE;
        endcase
    end

    // Owner index capture and pointer rotation on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= 2'b00;
            grant_id_r <= 2'b00;
        end else if (state_r == IDLE) begin
            grant_id_r <= pick_s.found ? pick_s.id : grant_id_r;
        end else if (release_s | expire_s) begin
            ptr_r <= grant_id_r + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Outputs derived only from registered state.
    always_comb begin
        dec_en_s    = 1'b0;
        grant_valid = 1'b0;
        if (state_r == BUSY) begin
            dec_en_s    = 1'b1;
            grant_valid = 1'b1;
        end else begin
            dec_en_s    = 1'b0;
            grant_valid = 1'b0;
        end
    end

    assign grant_id = grant_id_r;

    grant_dec_2to4 u_grant_dec (
        .id (grant_id_r),
        .en (dec_en_s),
        .y  (grant)
    );

endmodule
